// File: rtl/ensemble_pkg.sv
// Shared types and constants for the three-way ensemble vote controller.
package ensemble_pkg;

  localparam int unsigned NUM_CLASSIFIERS = 3;
  localparam logic [63:0] NO_RESULT = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FEED,
    ST_WAIT,
    ST_VOTE,
    ST_OUT
  } state_e;

endpackage

// File: rtl/ensemble_majority3.sv
// Combinational 2-of-3 majority over labels; absent labels are excluded from the vote.
module ensemble_majority3
  import ensemble_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [NUM_CLASSIFIERS*DATA_WIDTH-1:0] labels,
  input  logic [NUM_CLASSIFIERS-1:0]            present,
  output logic [DATA_WIDTH-1:0]                 winner,
  output logic                                  unanimous,
  output logic                                  tie
);

  logic [DATA_WIDTH-1:0] l0, l1, l2;
  logic                  eq01, eq02, eq12;

  assign l0   = labels[0*DATA_WIDTH +: DATA_WIDTH];
  assign l1   = labels[1*DATA_WIDTH +: DATA_WIDTH];
  assign l2   = labels[2*DATA_WIDTH +: DATA_WIDTH];
  assign eq01 = (l0 == l1);
  assign eq02 = (l0 == l2);
  assign eq12 = (l1 == l2);

  always_comb begin
    winner    = DATA_WIDTH'(NO_RESULT);
    unanimous = 1'b0;
    tie       = 1'b1;
    if (present == 3'b111) begin
      unanimous = eq01 && eq12;
      tie       = !(eq01 || eq02 || eq12);
      winner    = (eq12 && !eq01 && !eq02) ? l1 : l0;
    end else if (present == 3'b011 && eq01) begin
      winner = l0;
      tie    = 1'b0;
    end else if (present == 3'b101 && eq02) begin
      winner = l0;
      tie    = 1'b0;
    end else if (present == 3'b110 && eq12) begin
      winner = l1;
      tie    = 1'b0;
    end else if (present[0]) begin
      winner = l0;
    end else if (present[1]) begin
      winner = l1;
    end else if (present[2]) begin
      winner = l2;
    end
  end

endmodule

// File: rtl/ensemble_vote_ctrl.sv
// Broadcasts a sample to three classifiers, collects their labels and emits the majority vote.
// Optional WAIT watchdog enabled by defining ENSEMBLE_TIMEOUT_EN.
module ensemble_vote_ctrl
  import ensemble_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned KEEP_WIDTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [DATA_WIDTH-1:0]                 s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]                 s_axis_tkeep,
  input  logic                                  s_axis_tvalid,
  input  logic                                  s_axis_tlast,
  output logic                                  s_axis_tready,
  output logic [NUM_CLASSIFIERS*DATA_WIDTH-1:0] cls_axis_tdata,
  output logic [NUM_CLASSIFIERS*KEEP_WIDTH-1:0] cls_axis_tkeep,
  output logic [NUM_CLASSIFIERS-1:0]            cls_axis_tvalid,
  output logic [NUM_CLASSIFIERS-1:0]            cls_axis_tlast,
  input  logic [NUM_CLASSIFIERS-1:0]            cls_axis_tready,
  input  logic [NUM_CLASSIFIERS*DATA_WIDTH-1:0] res_axis_tdata,
  input  logic [NUM_CLASSIFIERS-1:0]            res_axis_tvalid,
  output logic [NUM_CLASSIFIERS-1:0]            res_axis_tready,
  output logic [DATA_WIDTH-1:0]                 m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]                 m_axis_tkeep,
  output logic                                  m_axis_tvalid,
  output logic                                  m_axis_tlast,
  input  logic                                  m_axis_tready,
  output logic                                  busy,
  output logic                                  vote_unanimous,
  output logic                                  vote_tie,
  output logic                                  timeout_err
);

  localparam int unsigned LBL_W = NUM_CLASSIFIERS * DATA_WIDTH;

  state_e                       state_q, state_d;
  logic [NUM_CLASSIFIERS-1:0]   mask_q, mask_d;
  logic [NUM_CLASSIFIERS-1:0]   captured_q, captured_d;
  logic [LBL_W-1:0]             labels_q, labels_d;
  logic                         m_tvalid_q, m_tvalid_d;
  logic [DATA_WIDTH-1:0]        m_tdata_q, m_tdata_d;
  logic                         unan_q, unan_d;
  logic                         tie_q, tie_d;
  logic                         busy_q, busy_d;
  logic                         tout_q, tout_d;

  logic [NUM_CLASSIFIERS-1:0]   cls_valid_c, accept_c, res_ready_c;
  logic                         s_ready_c;
  logic [DATA_WIDTH-1:0]        win_c;
  logic                         win_unan_c, win_tie_c;

`ifdef ENSEMBLE_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  ensemble_majority3 #(.DATA_WIDTH(DATA_WIDTH)) u_majority (
    .labels    (labels_q),
    .present   (captured_q),
    .winner    (win_c),
    .unanimous (win_unan_c),
    .tie       (win_tie_c)
  );

  // Next-state, handshake and capture logic.
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    captured_d  = captured_q;
    labels_d    = labels_q;
    m_tvalid_d  = m_tvalid_q;
    m_tdata_d   = m_tdata_q;
    unan_d      = unan_q;
    tie_d       = tie_q;
    tout_d      = 1'b0;
    cls_valid_c = '0;
    accept_c    = '0;
    res_ready_c = '0;
    s_ready_c   = 1'b0;
`ifdef ENSEMBLE_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        res_ready_c = '1;
        if (s_axis_tvalid) state_d = ST_FEED;
      end
      ST_FEED: begin
        if (s_axis_tvalid) begin
          cls_valid_c = ~mask_q;
          accept_c    = cls_valid_c & cls_axis_tready;
          if ((mask_q | accept_c) == '1) begin
            s_ready_c = 1'b1;
            mask_d    = '0;
            if (s_axis_tlast) begin
              state_d    = ST_WAIT;
              captured_d = '0;
`ifdef ENSEMBLE_TIMEOUT_EN
              cnt_d      = '0;
`endif
            end
          end else begin
            mask_d = mask_q | accept_c;
          end
        end
      end
      ST_WAIT: begin
        res_ready_c = ~captured_q;
        captured_d  = captured_q | (res_axis_tvalid & res_ready_c);
        for (int i = 0; i < NUM_CLASSIFIERS; i++) begin
          if (res_axis_tvalid[i] && res_ready_c[i])
            labels_d[i*DATA_WIDTH +: DATA_WIDTH] = res_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
        if (captured_d == '1) begin
          state_d = ST_VOTE;
`ifdef ENSEMBLE_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          tout_d  = 1'b1;
          state_d = ST_VOTE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      ST_VOTE: begin
        m_tvalid_d = 1'b1;
        m_tdata_d  = win_c;
        unan_d     = win_unan_c;
        tie_d      = win_tie_c;
        state_d    = ST_OUT;
      end
      ST_OUT: begin
        if (m_axis_tready) begin
          state_d    = ST_IDLE;
          m_tvalid_d = 1'b0;
          m_tdata_d  = '0;
          unan_d     = 1'b0;
          tie_d      = 1'b0;
          captured_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mask_q     <= '0;
      captured_q <= '0;
      labels_q   <= '0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      unan_q     <= 1'b0;
      tie_q      <= 1'b0;
      busy_q     <= 1'b0;
      tout_q     <= 1'b0;
`ifdef ENSEMBLE_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      captured_q <= captured_d;
      labels_q   <= labels_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      unan_q     <= unan_d;
      tie_q      <= tie_d;
      busy_q     <= busy_d;
      tout_q     <= tout_d;
`ifdef ENSEMBLE_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  // Handshake strobes are combinational and forced low while reset is held.
  assign s_axis_tready   = s_ready_c && !rst;
  assign cls_axis_tvalid = rst ? '0 : cls_valid_c;
  assign res_axis_tready = rst ? '0 : res_ready_c;
  assign cls_axis_tdata  = {NUM_CLASSIFIERS{s_axis_tdata}};
  assign cls_axis_tkeep  = {NUM_CLASSIFIERS{s_axis_tkeep}};
  assign cls_axis_tlast  = {NUM_CLASSIFIERS{s_axis_tlast}};

  assign m_axis_tvalid  = m_tvalid_q;
  assign m_axis_tdata   = m_tdata_q;
  assign m_axis_tkeep   = '1;
  assign m_axis_tlast   = m_tvalid_q;
  assign busy           = busy_q;
  assign vote_unanimous = unan_q;
  assign vote_tie       = tie_q;
`ifdef ENSEMBLE_TIMEOUT_EN
  assign timeout_err    = tout_q;
`else
  assign timeout_err    = 1'b0;
  logic unused_tout;
  assign unused_tout = tout_q;
`endif

endmodule

// File: tb/tb_ensemble_vote_ctrl.sv
// Randomized and directed bench for ensemble_vote_ctrl with a behavioural vote model.
module tb_ensemble_vote_ctrl;

  localparam int DW = 32;
  localparam int KW = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   s_axis_tdata;
  logic [KW-1:0]   s_axis_tkeep;
  logic            s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [3*DW-1:0] cls_axis_tdata;
  logic [3*KW-1:0] cls_axis_tkeep;
  logic [2:0]      cls_axis_tvalid, cls_axis_tlast, cls_axis_tready;
  logic [3*DW-1:0] res_axis_tdata;
  logic [2:0]      res_axis_tvalid, res_axis_tready;
  logic [DW-1:0]   m_axis_tdata;
  logic [KW-1:0]   m_axis_tkeep;
  logic            m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic            busy, vote_unanimous, vote_tie, timeout_err;

  ensemble_vote_ctrl #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .cls_axis_tdata(cls_axis_tdata), .cls_axis_tkeep(cls_axis_tkeep), .cls_axis_tvalid(cls_axis_tvalid),
    .cls_axis_tlast(cls_axis_tlast), .cls_axis_tready(cls_axis_tready),
    .res_axis_tdata(res_axis_tdata), .res_axis_tvalid(res_axis_tvalid), .res_axis_tready(res_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .busy(busy), .vote_unanimous(vote_unanimous), .vote_tie(vote_tie), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Transaction configuration shared by the helper tasks.
  logic [36:0] beat_log[$];
  int          src_ptr;
  int          stall_cfg[3];
  int          stall_left[3];
  int          cls_idx[3];
  logic [31:0] res_lbl[3];
  bit          res_en[3];
  int          res_at[3];
  bit          res_done[3];
  int          m_hold;
  bit          abort_on_cap;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_beats(input int n);
    beat_log.delete();
    for (int b = 0; b < n; b++)
      beat_log.push_back({4'($urandom_range(1, 15)), (b == n - 1), 32'($urandom)});
    src_ptr = 0;
  endtask

  task automatic set_res(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input int ta, input int tb, input int tc, input bit ea, input bit eb, input bit ec);
    res_lbl[0] = a;  res_lbl[1] = b;  res_lbl[2] = c;
    res_at[0]  = ta; res_at[1]  = tb; res_at[2]  = tc;
    res_en[0]  = ea; res_en[1]  = eb; res_en[2]  = ec;
  endtask

  task automatic drive_idle();
    s_axis_tvalid   = 1'b0;
    s_axis_tdata    = '0;
    s_axis_tkeep    = '0;
    s_axis_tlast    = 1'b0;
    cls_axis_tready = '0;
    res_axis_tvalid = '0;
    res_axis_tdata  = '0;
    m_axis_tready   = 1'b0;
  endtask

  // Run one transaction cycle by cycle; handshakes observed at #1 after negedge fire on the next posedge.
  task automatic run_txn(input string name);
    logic [31:0] exp_w;
    bit          exp_u, exp_t, found, all_en, done, drained;
    int          cnt, n, drain_n, last_cap, mv_first, tout_n, tout_cnt, s_pulses;
    logic [31:0] held;
    exp_w = 32'hFFFF_FFFF; exp_u = 0; exp_t = 1; found = 0;
    for (int i = 0; i < 3; i++) begin
      if (res_en[i] && !found) begin
        cnt = 0;
        for (int j = 0; j < 3; j++) if (res_en[j] && res_lbl[j] == res_lbl[i]) cnt++;
        if (cnt >= 2) begin exp_w = res_lbl[i]; exp_t = 0; exp_u = (cnt == 3); found = 1; end
      end
    end
    if (!found) begin
      for (int i = 2; i >= 0; i--) if (res_en[i]) exp_w = res_lbl[i];
    end
    all_en = res_en[0] && res_en[1] && res_en[2];
    for (int i = 0; i < 3; i++) begin
      stall_left[i] = stall_cfg[i]; cls_idx[i] = 0; res_done[i] = 0;
    end
    done = 0; drained = 0; n = 0; drain_n = 0; last_cap = -1; mv_first = -1;
    tout_n = -1; tout_cnt = 0; s_pulses = 0; held = '0;
    while (!done && n < 400) begin
      @(negedge clk);
      s_axis_tvalid = (src_ptr < beat_log.size());
      {s_axis_tkeep, s_axis_tlast, s_axis_tdata} = s_axis_tvalid ? beat_log[src_ptr] : 37'd0;
      for (int i = 0; i < 3; i++) begin
        cls_axis_tready[i] = (stall_left[i] == 0);
        res_axis_tvalid[i] = res_en[i] && !res_done[i] && drained && (n - drain_n >= res_at[i]);
        res_axis_tdata[i*DW +: DW] = res_lbl[i];
      end
      m_axis_tready = (mv_first >= 0) && (n - mv_first >= m_hold);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (cls_axis_tvalid[i]) begin
          if (cls_axis_tready[i]) begin
            if (cls_idx[i] < beat_log.size())
              chk({name, "_cls_beat"}, {cls_axis_tkeep[i*KW +: KW], cls_axis_tlast[i], cls_axis_tdata[i*DW +: DW]},
                  beat_log[cls_idx[i]]);
            cls_idx[i]++;
            stall_left[i] = stall_cfg[i];
          end else begin
            stall_left[i]--;
          end
        end
        if (res_axis_tvalid[i] && res_axis_tready[i]) begin res_done[i] = 1; last_cap = n; end
      end
      if (abort_on_cap && last_cap >= 0) break;
      if (s_axis_tready) begin
        s_pulses++;
        src_ptr++;
        if (src_ptr == beat_log.size()) begin drained = 1; drain_n = n + 1; end
      end
      if (timeout_err) begin tout_cnt++; tout_n = n; end
      if (m_axis_tvalid) begin
        if (mv_first < 0) begin mv_first = n; held = m_axis_tdata; end
        else chk({name, "_hold"}, m_axis_tdata, held);
        if (m_axis_tready) begin
          done = 1;
          chk({name, "_tdata"}, m_axis_tdata, exp_w);
          chk({name, "_flags"}, {m_axis_tkeep, m_axis_tlast, vote_unanimous, vote_tie}, {4'hF, 1'b1, exp_u, exp_t});
        end
      end
      n++;
    end
    if (abort_on_cap) return;
    if (!done) chk({name, "_no_output"}, 0, 1);
    for (int i = 0; i < 3; i++) chk({name, "_cls_count"}, cls_idx[i], beat_log.size());
    chk({name, "_s_pulses"}, s_pulses, beat_log.size());
    chk({name, "_tout_cnt"}, tout_cnt, all_en ? 0 : 1);
    if (all_en) chk({name, "_latency"}, mv_first - last_cap, 2);
    else begin
      chk({name, "_tout_at"}, tout_n - (drain_n - 1), TO + 1);
      chk({name, "_tout_to_valid"}, mv_first - tout_n, 1);
    end
    @(negedge clk);
    drive_idle();
    #1;
    chk({name, "_busy_after"}, {busy, m_axis_tvalid}, 2'b00);
  endtask

  initial begin
    int mv_seen;
    abort_on_cap = 0;
    m_hold = 0;
    drive_idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {s_axis_tready, cls_axis_tvalid, res_axis_tready, busy, m_axis_tvalid,
                          vote_unanimous, vote_tie, timeout_err}, 12'd0);
    chk("reset_tdata", m_axis_tdata, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_res_ready", {res_axis_tready, busy}, 4'b1110);

    // Single beat, unanimous 5.
    stall_cfg = '{0, 0, 0}; m_hold = 0;
    load_beats(1); set_res(5, 5, 5, 0, 0, 0, 1, 1, 1); run_txn("unanimous");

    // Four beats with classifier 1 stalling three cycles on every beat.
    stall_cfg = '{0, 3, 0};
    load_beats(4); set_res(8, 8, 1, 0, 1, 2, 1, 1, 1); run_txn("stall4");

    // Staggered results with output backpressure.
    stall_cfg = '{0, 0, 0}; m_hold = 5;
    load_beats(1); set_res(3, 7, 3, 0, 2, 4, 1, 1, 1); run_txn("split");

    // All distinct: tie, label 0 wins.
    m_hold = 0;
    load_beats(1); set_res(1, 2, 4, 1, 0, 0, 1, 1, 1); run_txn("tie");

`ifdef ENSEMBLE_TIMEOUT_EN
    // Classifier 2 silent: watchdog fires and votes on the two present labels.
    load_beats(1); set_res(9, 9, 0, 0, 1, 0, 1, 1, 0); run_txn("timeout");
`endif

    // Reset in WAIT after the first capture abandons the transaction.
    load_beats(2); set_res(6, 6, 6, 0, 30, 30, 1, 1, 1);
    abort_on_cap = 1; run_txn("abort"); abort_on_cap = 0;
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    #1;
    chk("rst_res_ready", {res_axis_tready, s_axis_tready, cls_axis_tvalid}, 7'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_state", {busy, m_axis_tvalid, vote_unanimous, vote_tie}, 4'd0);
    chk("post_rst_tdata", m_axis_tdata, 0);
    mv_seen = 0;
    repeat (6) begin @(negedge clk); #1; if (m_axis_tvalid) mv_seen++; end
    chk("post_rst_no_output", mv_seen, 0);
    load_beats(1); set_res(6, 6, 2, 0, 0, 0, 1, 1, 1); run_txn("after_rst");

    // Randomized transactions.
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < 3; i++) stall_cfg[i] = $urandom_range(0, 3);
      m_hold = $urandom_range(0, 3);
      load_beats($urandom_range(1, 4));
      set_res($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5), 1, 1, 1);
      run_txn("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
